// File: rtl/dedicated_datapath_pkg.sv
// Shared types and defaults for the dedicated datapath and its controller.
package dedicated_datapath_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int LE_LIMIT_DEF = 10;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_NOT  = 3'b101,
        ALU_RSV6 = 3'b110,
        ALU_RSV7 = 3'b111
    } alu_op_e;

endpackage

// File: rtl/dedicated_datapath_register_file.sv
// 8 x DATA_W register file: two asynchronous read ports, one synchronous write port.
// R0 is hard-wired to zero; reads return the pre-write value on a same-cycle write.
module register_file
    import dedicated_datapath_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [2:0]        wr_addr_i,
    input  logic [DATA_W-1:0] wr_dat_i,
    input  logic [2:0]        rd_addr1_i,
    input  logic [2:0]        rd_addr2_i,
    output logic [DATA_W-1:0] rd_dat1_o,
    output logic [DATA_W-1:0] rd_dat2_o
);

    logic [DATA_W-1:0] regs_q [8];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_i && (wr_addr_i != 3'd0)) begin
            regs_q[wr_addr_i] <= wr_dat_i;
        end
    end

    assign rd_dat1_o = (rd_addr1_i == 3'd0) ? '0 : regs_q[rd_addr1_i];
    assign rd_dat2_o = (rd_addr2_i == 3'd0) ? '0 : regs_q[rd_addr2_i];

endmodule

// File: rtl/dedicated_datapath.sv
// Datapath: register file, combinational ALU, write-source mux, registered output buffer and <=LE_LIMIT flag.
// outPort/iLe10 update one edge after their enables; synchronous reset overrides all enables.
module dedicated_datapath
    import dedicated_datapath_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LE_LIMIT = LE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RFSrcMuxSel,
    input  logic [2:0]        aluOp,
    input  logic [2:0]        readAddr1,
    input  logic [2:0]        readAddr2,
    input  logic [2:0]        writeAddr,
    input  logic              writeEn,
    input  logic              outBuf,
    output logic              iLe10,
    output logic [DATA_W-1:0] outPort
);

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] wr_dat;
    logic              commit_wr;
    logic [DATA_W-1:0] out_port_d, out_port_q;
    logic              ile_d, ile_q;

    register_file #(.DATA_W(DATA_W)) u_rf (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (writeEn),
        .wr_addr_i  (writeAddr),
        .wr_dat_i   (wr_dat),
        .rd_addr1_i (readAddr1),
        .rd_addr2_i (readAddr2),
        .rd_dat1_o  (op_a),
        .rd_dat2_o  (op_b)
    );

    // Arithmetic wraps naturally at DATA_W; carry/borrow are dropped.
    always_comb begin
        alu_res = '0;
        case (alu_op_e'(aluOp))
            ALU_ADD: alu_res = op_a + op_b;
            ALU_SUB: alu_res = op_a - op_b;
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_XOR: alu_res = op_a ^ op_b;
            ALU_NOT: alu_res = ~op_a;
            default: alu_res = '0;
        endcase
    end

    assign wr_dat    = RFSrcMuxSel ? DATA_W'(1) : alu_res;
    assign commit_wr = writeEn && (writeAddr != 3'd0);

    // The flag tracks only writes that actually land in the register file.
    always_comb begin
        out_port_d = out_port_q;
        ile_d      = ile_q;
        if (outBuf) begin
            out_port_d = alu_res;
        end
        if (commit_wr) begin
            ile_d = (wr_dat <= DATA_W'(LE_LIMIT));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_port_q <= '0;
            ile_q      <= 1'b0;
        end else begin
            out_port_q <= out_port_d;
            ile_q      <= ile_d;
        end
    end

    assign outPort = out_port_q;
    assign iLe10   = ile_q;

endmodule

// File: tb/tb_dedicated_datapath.sv
// Scoreboard bench: stimulus pushes expected outPort/iLe10 from a reference model; a monitor pops and compares after each edge.
module tb_dedicated_datapath;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       RFSrcMuxSel = 1'b0;
    logic [2:0] aluOp = 3'd0;
    logic [2:0] readAddr1 = 3'd0;
    logic [2:0] readAddr2 = 3'd0;
    logic [2:0] writeAddr = 3'd0;
    logic       writeEn = 1'b0;
    logic       outBuf = 1'b0;
    logic       iLe10;
    logic [7:0] outPort;

    dedicated_datapath #(.DATA_W(8), .LE_LIMIT(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .RFSrcMuxSel (RFSrcMuxSel),
        .aluOp       (aluOp),
        .readAddr1   (readAddr1),
        .readAddr2   (readAddr2),
        .writeAddr   (writeAddr),
        .writeEn     (writeEn),
        .outBuf      (outBuf),
        .iLe10       (iLe10),
        .outPort     (outPort)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] out;
        logic       le;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   step_id = 0;

    logic [7:0] m_r [8];
    logic [7:0] m_out;
    logic       m_le;

    function automatic logic [7:0] model_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int r;
        case (op)
            3'd0: r = (int'(a) + int'(b)) % 256;
            3'd1: r = (int'(a) - int'(b) + 256) % 256;
            3'd2: r = int'(a & b);
            3'd3: r = int'(a | b);
            3'd4: r = int'(a ^ b);
            3'd5: r = 255 - int'(a);
            default: r = 0;
        endcase
        return 8'(r);
    endfunction

    task automatic step(input logic rfsel, input logic [2:0] op, input logic [2:0] a1,
                        input logic [2:0] a2, input logic [2:0] wa, input logic we,
                        input logic ob, input logic rst);
        logic [7:0] res;
        logic [7:0] wd;
        exp_t e;
        @(negedge clk);
        RFSrcMuxSel = rfsel; aluOp = op; readAddr1 = a1; readAddr2 = a2;
        writeAddr = wa; writeEn = we; outBuf = ob; reset = rst;
        res = model_alu(op, (a1 == 0) ? 8'd0 : m_r[a1], (a2 == 0) ? 8'd0 : m_r[a2]);
        wd  = rfsel ? 8'd1 : res;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_r[i] = 8'd0;
            m_out = 8'd0;
            m_le  = 1'b0;
        end else begin
            if (ob) m_out = res;
            if (we && wa != 0) begin
                m_r[wa] = wd;
                m_le = (int'(wd) <= 10);
            end
        end
        step_id++;
        e.id = step_id; e.out = m_out; e.le = m_le;
        exp_q.push_back(e);
    endtask

    // Observe Rn through the ALU: Rn | Rn loaded into the output buffer.
    task automatic read_reg(input logic [2:0] n);
        step(1'b0, 3'd3, n, n, 3'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic wr(input logic [2:0] wa, input logic [2:0] op, input logic [2:0] a1, input logic [2:0] a2);
        step(1'b0, op, a1, a2, wa, 1'b1, 1'b0, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (outPort !== e.out) begin
                bad++;
                $display("FAIL outPort step=%0d got=%h want=%h", e.id, outPort, e.out);
            end
            total++;
            if (iLe10 !== e.le) begin
                bad++;
                $display("FAIL iLe10 step=%0d got=%b want=%b", e.id, iLe10, e.le);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) m_r[i] = 8'd0;
        m_out = 8'd0;
        m_le  = 1'b0;

        // Reset overrides writeEn/outBuf in the same cycle.
        step(1'b1, 3'd0, 3'd1, 3'd1, 3'd3, 1'b1, 1'b1, 1'b1);
        for (int n = 0; n < 8; n++) read_reg(3'(n));

        // Controller sequence.
        step(1'b1, 3'd0, 3'd0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0);
        wr(3'd2, 3'd2, 3'd0, 3'd0);
        wr(3'd3, 3'd2, 3'd0, 3'd0);
        wr(3'd4, 3'd0, 3'd1, 3'd1);
        wr(3'd5, 3'd0, 3'd4, 3'd4);
        wr(3'd6, 3'd1, 3'd5, 3'd1);
        wr(3'd2, 3'd2, 3'd6, 3'd4);
        wr(3'd3, 3'd3, 3'd2, 3'd5);
        wr(3'd7, 3'd4, 3'd3, 3'd2);
        step(1'b0, 3'd5, 3'd7, 3'd0, 3'd4, 1'b1, 1'b1, 1'b0);
        for (int n = 1; n < 8; n++) read_reg(3'(n));

        // Wrap-around: R1 = ~R0 = 0xFF, R2 = R1+R1, R3 = R0-R1.
        wr(3'd1, 3'd5, 3'd0, 3'd0);
        wr(3'd2, 3'd0, 3'd1, 3'd1);
        wr(3'd3, 3'd1, 3'd0, 3'd1);
        read_reg(3'd2);
        read_reg(3'd3);

        // Writes to R0 are dropped and leave the flag alone.
        step(1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        read_reg(3'd0);

        // Flag threshold: 10 -> 1, 11 -> 0, outBuf-only cycle holds it.
        step(1'b1, 3'd0, 3'd0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0);
        wr(3'd2, 3'd0, 3'd1, 3'd1);
        wr(3'd3, 3'd0, 3'd2, 3'd2);
        wr(3'd4, 3'd0, 3'd3, 3'd3);
        wr(3'd5, 3'd0, 3'd4, 3'd2);
        wr(3'd5, 3'd0, 3'd5, 3'd1);
        step(1'b0, 3'd0, 3'd5, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);

        // Same-cycle read/write of R3 sees the old value, new value next cycle.
        wr(3'd3, 3'd1, 3'd4, 3'd1);
        step(1'b0, 3'd3, 3'd3, 3'd0, 3'd3, 1'b1, 1'b1, 1'b0);
        read_reg(3'd3);

        // Reset mid-sequence discards the in-flight write; next write is normal.
        step(1'b1, 3'd0, 3'd0, 3'd0, 3'd6, 1'b1, 1'b1, 1'b1);
        read_reg(3'd6);
        step(1'b1, 3'd0, 3'd0, 3'd0, 3'd6, 1'b1, 1'b0, 1'b0);
        read_reg(3'd6);

        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 3) == 0), 3'($urandom), 3'($urandom), 3'($urandom),
                 3'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom),
                 1'($urandom_range(0, 39) == 0));
        end
        for (int n = 0; n < 8; n++) read_reg(3'(n));

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
